// File: rtl/ibex_pkg.sv
// Shared execution-stage definitions: sequencer states, functional-unit
// indices and latency-counter sizing.
package ibex_pkg;

    typedef enum logic [1:0] {
        EX_SEQ_IDLE = 2'd0,
        EX_SEQ_BUSY = 2'd1,
        EX_SEQ_DONE = 2'd2
    } ex_seq_state_e;

    localparam int EX_FU_ALU    = 0;
    localparam int EX_FU_MULDIV = 1;
    localparam int EX_FU_FPU    = 2;

    localparam int EX_FU_MAX_LAT = 15;
    localparam int EX_LAT_CNT_W  = 4;

endpackage

// File: rtl/ibex_ex_lat_cnt.sv
// Loadable 4-bit down-counter. done_o marks the last cycle of a fixed-latency
// operation, i.e. the cycle in which the unit's result must be sampled.
module ibex_ex_lat_cnt
    import ibex_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [EX_LAT_CNT_W-1:0] load_val_i,
    input  logic                    dec_i,
    output logic                    done_o
);

    logic [EX_LAT_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (dec_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Loaded with L at the end of the issue cycle, so it reads 1 in cycle L.
    assign done_o = (r_cnt == EX_LAT_CNT_W'(1));

endmodule

// File: rtl/ibex_ex_fu_sequencer.sv
// Execution-stage sequencer: issues one operation at a time to a functional
// unit, waits for its fixed or handshaked latency and holds the result for writeback.
module ibex_ex_fu_sequencer
    import ibex_pkg::*;
#(
    parameter int NumFu               = 3,
    parameter int DataWidth           = 32,
    parameter int FuLatency [NumFu]   = '{0, 0, 3},
    localparam int FuIdxW             = (NumFu > 1) ? $clog2(NumFu) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       issue_valid_i,
    input  logic [FuIdxW-1:0]          issue_fu_i,
    output logic                       issue_ready_o,
    output logic [NumFu-1:0]           fu_start_o,
    output logic [NumFu-1:0]           fu_kill_o,
    input  logic [NumFu-1:0]           fu_valid_i,
    input  logic [NumFu*DataWidth-1:0] fu_result_i,
    input  logic                       flush_i,
    input  logic                       wb_ready_i,
    output logic                       result_valid_o,
    output logic [DataWidth-1:0]       result_o,
    output logic [FuIdxW-1:0]          result_fu_o,
    output logic                       result_err_o,
    output logic                       busy_o
);

    ex_seq_state_e r_state;
    ex_seq_state_e w_state_d;

    logic [FuIdxW-1:0]       r_sel;
    logic [DataWidth-1:0]    r_result;
    logic                    r_err;

    logic [EX_LAT_CNT_W-1:0] w_lat_tab [NumFu];
    logic                    w_idx_ok;
    logic [EX_LAT_CNT_W-1:0] w_issue_lat;
    logic [EX_LAT_CNT_W-1:0] w_sel_lat;
    logic                    w_sel_valid;
    logic [DataWidth-1:0]    w_sel_result;
    logic                    w_accept;
    logic                    w_capture;
    logic                    w_cnt_done;

    for (genvar k = 0; k < NumFu; k++) begin : g_lat
        assign w_lat_tab[k] = (FuLatency[k] > EX_FU_MAX_LAT) ? EX_LAT_CNT_W'(EX_FU_MAX_LAT)
                                                             : EX_LAT_CNT_W'(FuLatency[k]);
    end

    // Per-FU selection for the incoming index and for the in-flight unit.
    always_comb begin
        w_idx_ok     = (32'(issue_fu_i) < 32'(NumFu));
        w_issue_lat  = '0;
        w_sel_lat    = '0;
        w_sel_valid  = 1'b0;
        w_sel_result = '0;
        for (int k = 0; k < NumFu; k++) begin
            if (issue_fu_i == FuIdxW'(k)) begin
                w_issue_lat = w_lat_tab[k];
            end
            if (r_sel == FuIdxW'(k)) begin
                w_sel_lat    = w_lat_tab[k];
                w_sel_valid  = fu_valid_i[k];
                w_sel_result = fu_result_i[k*DataWidth +: DataWidth];
            end
        end
    end

    ibex_ex_lat_cnt u_lat_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (flush_i),
        .load_i     (w_accept && w_idx_ok),
        .load_val_i (w_issue_lat),
        .dec_i      (r_state == EX_SEQ_BUSY),
        .done_o     (w_cnt_done)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= EX_SEQ_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        issue_ready_o = 1'b0;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        fu_start_o    = '0;
        fu_kill_o     = '0;

        issue_ready_o = rst_ni && !flush_i &&
                        ((r_state == EX_SEQ_IDLE) || ((r_state == EX_SEQ_DONE) && wb_ready_i));
        w_accept      = issue_valid_i && issue_ready_o;
        // A zero latency entry means the unit signals completion itself.
        w_capture     = (r_state == EX_SEQ_BUSY) && !flush_i &&
                        ((w_sel_lat == '0) ? w_sel_valid : w_cnt_done);

        for (int k = 0; k < NumFu; k++) begin
            fu_start_o[k] = w_accept && w_idx_ok && (issue_fu_i == FuIdxW'(k));
            fu_kill_o[k]  = rst_ni && flush_i && (r_state == EX_SEQ_BUSY) && (r_sel == FuIdxW'(k));
        end

        case (r_state)
            EX_SEQ_IDLE: begin
                if (w_accept) begin
                    w_state_d = w_idx_ok ? EX_SEQ_BUSY : EX_SEQ_DONE;
                end
            end
            EX_SEQ_BUSY: begin
                if (w_capture) begin
                    w_state_d = EX_SEQ_DONE;
                end
            end
            EX_SEQ_DONE: begin
                if (w_accept) begin
                    w_state_d = w_idx_ok ? EX_SEQ_BUSY : EX_SEQ_DONE;
                end else if (wb_ready_i) begin
                    w_state_d = EX_SEQ_IDLE;
                end
            end
            default: w_state_d = EX_SEQ_IDLE;
        endcase

        if (flush_i) begin
            w_state_d = EX_SEQ_IDLE;
        end
    end

    // Accept and capture never coincide: accept needs IDLE/DONE, capture needs BUSY.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sel    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_sel <= issue_fu_i;
            r_err <= !w_idx_ok;
            if (!w_idx_ok) begin
                r_result <= '0;
            end
        end else if (w_capture) begin
            r_result <= w_sel_result;
        end
    end

    assign result_valid_o = (r_state == EX_SEQ_DONE);
    assign result_o       = r_result;
    assign result_fu_o    = r_sel;
    assign result_err_o   = r_err;
    assign busy_o         = (r_state != EX_SEQ_IDLE);

endmodule

// File: tb/tb_ibex_ex_fu_sequencer.sv
// Directed bench for ibex_ex_fu_sequencer with a cycle-level reference model
// checked on every falling edge, plus hand-computed expectations.
module tb_ibex_ex_fu_sequencer;
    import ibex_pkg::*;

    localparam int NFU = 3;
    localparam int DW  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            issue_valid;
    logic [1:0]      issue_fu;
    logic            issue_ready;
    logic [NFU-1:0]  fu_start;
    logic [NFU-1:0]  fu_kill;
    logic [NFU-1:0]  fu_valid;
    logic [NFU*DW-1:0] fu_result;
    logic            flush;
    logic            wb_ready;
    logic            result_valid;
    logic [DW-1:0]   result;
    logic [1:0]      result_fu;
    logic            result_err;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    ibex_ex_fu_sequencer dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .issue_valid_i  (issue_valid),
        .issue_fu_i     (issue_fu),
        .issue_ready_o  (issue_ready),
        .fu_start_o     (fu_start),
        .fu_kill_o      (fu_kill),
        .fu_valid_i     (fu_valid),
        .fu_result_i    (fu_result),
        .flush_i        (flush),
        .wb_ready_i     (wb_ready),
        .result_valid_o (result_valid),
        .result_o       (result),
        .result_fu_o    (result_fu),
        .result_err_o   (result_err),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an operation is "active" from the cycle after issue
    // until its result arrives; age counts cycles since the issue cycle.
    int   lat_tab [NFU] = '{0, 0, 3};
    bit   m_active = 0;
    bit   m_held   = 0;
    int   m_fu     = 0;
    int   m_age    = 0;
    logic [DW-1:0] m_res = '0;
    bit   m_err    = 0;

    always @(negedge clk) begin
        bit e_ready, e_acc, e_cap;
        logic [NFU-1:0] e_start, e_kill;
        e_ready = rst_n && !flush && !m_active && (!m_held || wb_ready);
        e_acc   = issue_valid && e_ready;
        e_start = (e_acc && issue_fu < NFU) ? NFU'(1 << issue_fu) : '0;
        e_kill  = (rst_n && flush && m_active) ? NFU'(1 << m_fu) : '0;
        if (m_active && lat_tab[m_fu] == 0) begin
            e_cap = rst_n && !flush && m_age >= 1 && fu_valid[m_fu];
        end else begin
            e_cap = rst_n && !flush && m_active && m_age == lat_tab[m_fu];
        end

        chk("m_ready", issue_ready, e_ready);
        chk("m_start", fu_start, e_start);
        chk("m_kill", fu_kill, e_kill);
        chk("m_valid", result_valid, m_held);
        chk("m_busy", busy, m_active || m_held);
        if (m_held) begin
            chk("m_result", result, m_res);
            chk("m_fu", result_fu, m_fu);
            chk("m_err", result_err, m_err);
        end

        if (!rst_n) begin
            m_active = 0; m_held = 0; m_fu = 0; m_age = 0; m_res = '0; m_err = 0;
        end else if (flush) begin
            m_active = 0; m_held = 0;
        end else begin
            if (e_cap) begin
                m_active = 0;
                m_held   = 1;
                m_res    = fu_result[m_fu*DW +: DW];
            end else if (m_active) begin
                m_age++;
            end
            if (m_held && wb_ready) m_held = 0;
            if (e_acc) begin
                m_fu  = int'(issue_fu);
                if (issue_fu < NFU) begin
                    m_active = 1; m_age = 1; m_err = 0;
                end else begin
                    m_held = 1; m_res = '0; m_err = 1;
                end
            end
        end
    end

    initial begin
        rst_n = 0; issue_valid = 0; issue_fu = 0; fu_valid = '0;
        fu_result = '0; flush = 0; wb_ready = 0;
        repeat (2) @(posedge clk);
        #1; #2;
        chk("rst_ready", issue_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        rst_n = 1;
        #1;
        chk("rel_ready", issue_ready, 1);

        // FPU fixed latency 3
        cyc(); issue_valid = 1; issue_fu = 2'(EX_FU_FPU); #2;
        chk("fpu_start", fu_start, 3'b100);
        cyc(); issue_valid = 0;
        cyc();
        cyc(); fu_result[2*DW +: DW] = 32'h3F80_0000; #2;
        chk("fpu_c3_valid", result_valid, 0);
        cyc(); #2;
        chk("fpu_c4_valid", result_valid, 1);
        chk("fpu_c4_result", result, 32'h3F80_0000);
        chk("fpu_c4_fu", result_fu, 2);
        wb_ready = 1;
        cyc(); wb_ready = 0; #2;
        chk("fpu_c5_busy", busy, 0);

        // Variable-latency muldiv, cycle-0 valid and foreign valid ignored
        cyc(); issue_valid = 1; issue_fu = 2'(EX_FU_MULDIV); fu_valid = 3'b010;
        cyc(); issue_valid = 0; fu_valid = 3'b000; #2;
        chk("md_c1_busy", busy, 1);
        chk("md_c1_valid", result_valid, 0);
        cyc();
        cyc(); fu_valid = 3'b001; fu_result[0 +: DW] = 32'hDEAD;
        cyc(); fu_valid = 3'b000;
        cyc();
        cyc(); fu_valid = 3'b010; fu_result[DW +: DW] = 32'd42; #2;
        chk("md_c6_valid", result_valid, 0);
        cyc(); fu_valid = 3'b000; #2;
        chk("md_c7_valid", result_valid, 1);
        chk("md_c7_result", result, 42);
        chk("md_c7_err", result_err, 0);

        // Back-to-back issue from DONE
        wb_ready = 1; issue_valid = 1; issue_fu = 2'(EX_FU_MULDIV); #1;
        chk("b2b_ready", issue_ready, 1);
        chk("b2b_start", fu_start, 3'b010);
        cyc(); wb_ready = 0; issue_valid = 0; fu_valid = 3'b010;
        fu_result[DW +: DW] = 32'd7; #2;
        chk("b2b_busy", busy, 1);
        chk("b2b_valid", result_valid, 0);
        cyc(); fu_valid = 3'b000; #2;
        chk("b2b_result", result, 7);
        wb_ready = 1;
        cyc(); wb_ready = 0; #2;
        chk("b2b_idle", busy, 0);

        // Flush while BUSY with a concurrent issue
        cyc(); issue_valid = 1; issue_fu = 2'(EX_FU_FPU);
        cyc(); issue_valid = 0;
        cyc(); flush = 1; issue_valid = 1; issue_fu = 2'(EX_FU_ALU); #2;
        chk("fl_kill", fu_kill, 3'b100);
        chk("fl_ready", issue_ready, 0);
        chk("fl_start", fu_start, 3'b000);
        cyc(); flush = 0; issue_valid = 0; #2;
        chk("fl_idle", busy, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            chk("fl_novalid", result_valid, 0);
        end

        // Invalid FU index
        cyc(); issue_valid = 1; issue_fu = 2'd3; #2;
        chk("inv_start", fu_start, 3'b000);
        chk("inv_ready", issue_ready, 1);
        cyc(); issue_valid = 0; #2;
        chk("inv_valid", result_valid, 1);
        chk("inv_result", result, 0);
        chk("inv_err", result_err, 1);
        chk("inv_fu", result_fu, 3);
        wb_ready = 1;
        cyc(); wb_ready = 0; #2;
        chk("inv_idle", busy, 0);

        // Reset while BUSY
        cyc(); issue_valid = 1; issue_fu = 2'(EX_FU_FPU);
        cyc(); issue_valid = 0; rst_n = 0; #2;
        chk("rb_kill", fu_kill, 3'b000);
        chk("rb_ready", issue_ready, 0);
        cyc(); #2;
        chk("rb_busy", busy, 0);
        chk("rb_fu", result_fu, 0);
        chk("rb_err", result_err, 0);
        chk("rb_result", result, 0);
        rst_n = 1;

        // DONE held with wb_ready low for 5 cycles
        cyc(); issue_valid = 1; issue_fu = 2'(EX_FU_ALU);
        cyc(); issue_valid = 0; fu_valid = 3'b001; fu_result[0 +: DW] = 32'h55;
        cyc(); fu_valid = 3'b000; issue_valid = 1; issue_fu = 2'(EX_FU_MULDIV); #2;
        chk("hold_valid", result_valid, 1);
        chk("hold_result", result, 32'h55);
        chk("hold_ready", issue_ready, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(); fu_valid = 3'b001; fu_result[0 +: DW] = $urandom_range(256, 65535); #2;
            chk("hold_result", result, 32'h55);
            chk("hold_ready", issue_ready, 0);
        end
        cyc(); fu_valid = 3'b000; issue_valid = 0; wb_ready = 1;
        cyc(); wb_ready = 0; #2;
        chk("hold_idle", busy, 0);

        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
